// File: rtl/matrix_pkg.sv
// Shared types and default sizing for the matrix operand loader.
// N_ELEM/IDX_W describe the default 3x3 configuration; parameterised users derive their own.
package matrix_pkg;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} ldr_state_t;

  localparam int DEF_DIM = 3;
  localparam int DEF_DW  = 8;
  localparam int N_ELEM  = DEF_DIM * DEF_DIM;
  localparam int IDX_W   = $clog2(N_ELEM);

endpackage

// File: rtl/matrix_operand_bank.sv
// N_ELEM x DW register bank with a single indexed write port, flattened row-major.
module operand_bank
  import matrix_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  parameter int DW  = DEF_DW
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                we,
  input  logic [$clog2(DIM*DIM)-1:0]          idx,
  input  logic [DW-1:0]                       wdata,
  output logic [DIM*DIM*DW-1:0]               flat
);

  localparam int NUM_EL = DIM * DIM;

  // element storage; unwritten elements keep their value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flat <= {(NUM_EL*DW){1'b0}};
    end else if (we) begin
      flat[int'(idx)*DW +: DW] <= wdata;
    end else begin
      flat <= flat;
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Byte-serial loader: streams A then B (or A only in B-reuse mode) into two operand banks
// and holds them in FULL until the multiplier core consumes them.
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  parameter int DW  = DEF_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DW-1:0]            data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic                     keep_b,
  input  logic                     consume,
  output logic                     done,
  output logic                     overflow,
  output logic [DIM*DIM*DW-1:0]    a_flat,
  output logic [DIM*DIM*DW-1:0]    b_flat
);

  localparam int NUM_EL   = DIM * DIM;
  localparam int IDX_BITS = $clog2(NUM_EL);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_EL - 1);
  localparam logic [IDX_BITS-1:0] ONE_IDX  = IDX_BITS'(1);
  localparam logic [IDX_BITS-1:0] ZERO_IDX = IDX_BITS'(0);

  ldr_state_t           state_r, state_next_s;
  logic [IDX_BITS-1:0]  idx_r, idx_next_s;
  logic                 keep_b_q_r, keep_b_next_s;
  logic                 done_r, ready_r, overflow_r;
  logic                 accept_s, we_a_s, we_b_s;

  // ready is a registered decode of state, so accept has no input-to-ready loop
  assign accept_s   = enable & data_valid & ready_r;
  assign data_ready = ready_r;
  assign done       = done_r;
  assign overflow   = overflow_r;

  // control state, element index and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= LOAD_A;
      idx_r      <= ZERO_IDX;
      keep_b_q_r <= 1'b0;
      done_r     <= 1'b0;
      ready_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      idx_r      <= idx_next_s;
      keep_b_q_r <= keep_b_next_s;
      done_r     <= (state_next_s == FULL);
      ready_r    <= (state_next_s != FULL);
      overflow_r <= overflow_r | (enable & data_valid & (state_r == FULL));
    end
  end

  // next-state, index advance and bank write enables
  always_comb begin
    state_next_s  = state_r;
    idx_next_s    = idx_r;
    keep_b_next_s = keep_b_q_r;
    we_a_s        = 1'b0;
    we_b_s        = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (accept_s) begin
          we_a_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            idx_next_s   = ZERO_IDX;
            state_next_s = keep_b_q_r ? FULL : LOAD_B;
          end else begin
            idx_next_s = idx_r + ONE_IDX;
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      LOAD_B: begin
        if (accept_s) begin
          we_b_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            idx_next_s   = ZERO_IDX;
            state_next_s = FULL;
          end else begin
            idx_next_s = idx_r + ONE_IDX;
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      FULL: begin
        if (consume) begin
          keep_b_next_s = keep_b;
          state_next_s  = LOAD_A;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = LOAD_A;
        idx_next_s   = ZERO_IDX;
      end
    endcase
  end

  operand_bank #(.DIM(DIM), .DW(DW)) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (we_a_s),
    .idx   (idx_r),
    .wdata (data_in),
    .flat  (a_flat)
  );

  operand_bank #(.DIM(DIM), .DW(DW)) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (we_b_s),
    .idx   (idx_r),
    .wdata (data_in),
    .flat  (b_flat)
  );

endmodule
